axi_rd_arbiter: RTL and testbench

Round-robin arbiter that lets `NUM_REQ` HLS read masters share one AXI read path of the AXI bridge (the `axi_ar_V` / `axi_r_V` ap_vld/ap_ack ports). It grants one AR request at a time, forwards it downstream, and records the owner of each issued burst in an in-order owner FIFO. It then steers returning R beats to the owning requester until RLAST. It sits between the accelerator's read engines (weight loader, feature-map loader) and the bridge.

---
 rtl/axi_rd_arb_pkg.sv | 20 ++
 rtl/rd_owner_fifo.sv | 65 ++++++
 rtl/axi_rd_arbiter.sv | 140 ++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_arb_pkg.sv
// Shared types and width helpers for the AXI read-path arbiter.
package axi_rd_arb_pkg;

    localparam int AR_W = 40;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } ar_state_e;

    // Index width for n requesters or n FIFO slots, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rd_owner_fifo.sv
// In-order record of which requester owns each outstanding read burst.
module rd_owner_fifo
    import axi_rd_arb_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = id_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential blocks use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read path between NUM_REQ HLS read masters;
// AR requests are granted one at a time and R beats are steered to the burst owner.
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int AXI_DATA_WIDTH = 512,
    parameter int MAX_OUTST      = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESETN,
    input  logic [NUM_REQ*AR_W-1:0]     req_ar,
    input  logic [NUM_REQ-1:0]          req_ar_vld,
    output logic [NUM_REQ-1:0]          req_ar_ack,
    output logic [AXI_DATA_WIDTH:0]     req_r,
    output logic [NUM_REQ-1:0]          req_r_vld,
    input  logic [NUM_REQ-1:0]          req_r_ack,
    output logic [AR_W-1:0]             axi_ar_V,
    output logic                        axi_ar_V_ap_vld,
    input  logic                        axi_ar_V_ap_ack,
    input  logic [AXI_DATA_WIDTH:0]     axi_r_V,
    input  logic                        axi_r_V_ap_vld,
    output logic                        axi_r_V_ap_ack
);

    localparam int ID_W = id_width(NUM_REQ);

    ar_state_e        state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  grant_q, grant_d;
    logic [AR_W-1:0]  ar_word_q, ar_word_d;

    logic [ID_W-1:0]  sel_idx;
    logic [ID_W-1:0]  scan_idx;
    logic             sel_found;
    logic [AR_W-1:0]  sel_word;
    logic             grant_en;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ID_W-1:0]  head;

    // Scan from rr_ptr upward, wrapping, and take the first valid requester.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!sel_found && req_ar_vld[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
        sel_word = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (sel_idx == ID_W'(k)) sel_word = req_ar[k*AR_W +: AR_W];
        end
    end

    // Gated by ARESETN so no ack leaks out while the block is held in reset.
    assign grant_en = ARESETN && (state_q == IDLE) && !fifo_full && sel_found;

    always_comb begin
        req_ar_ack = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_ar_ack[k] = grant_en && (sel_idx == ID_W'(k));
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        ar_word_d = ar_word_q;
        fifo_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    grant_d   = sel_idx;
                    ar_word_d = sel_word;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (axi_ar_V_ap_ack) begin
                    fifo_push = 1'b1;
                    rr_ptr_d  = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + ID_W'(1);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            ar_word_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            ar_word_q <= ar_word_d;
        end
    end

    assign axi_ar_V        = ar_word_q;
    assign axi_ar_V_ap_vld = (state_q == ISSUE);

    // R beats only flow while some burst is outstanding; stray beats stall.
    always_comb begin
        req_r_vld      = '0;
        axi_r_V_ap_ack = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!fifo_empty && (head == ID_W'(k))) begin
                req_r_vld[k]   = axi_r_V_ap_vld;
                axi_r_V_ap_ack = req_r_ack[k];
            end
        end
    end

    assign req_r    = axi_r_V;
    assign fifo_pop = axi_r_V_ap_vld && axi_r_V_ap_ack && axi_r_V[AXI_DATA_WIDTH];

    rd_owner_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTST)
    ) u_owner_fifo (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .push      (fifo_push),
        .push_data (grant_q),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with AR and R scoreboards.
module tb_axi_rd_arbiter;

    localparam int NR = 2;
    localparam int DW = 32;
    localparam int MO = 4;

    logic            ACLK;
    logic            ARESETN;
    logic [NR*40-1:0] req_ar;
    logic [NR-1:0]   req_ar_vld;
    logic [NR-1:0]   req_ar_ack;
    logic [DW:0]     req_r;
    logic [NR-1:0]   req_r_vld;
    logic [NR-1:0]   req_r_ack;
    logic [39:0]     axi_ar_V;
    logic            axi_ar_V_ap_vld;
    logic            axi_ar_V_ap_ack;
    logic [DW:0]     axi_r_V;
    logic            axi_r_V_ap_vld;
    logic            axi_r_V_ap_ack;

    typedef struct {
        logic [NR-1:0] vld;
        logic [DW:0]   word;
    } r_exp_t;

    r_exp_t      r_sb[$];
    logic [39:0] ar_sb[$];
    int          checks = 0;
    int          errors = 0;

    localparam logic [39:0] W0 = 40'h01_0000_2000;
    localparam logic [39:0] W1 = 40'h03_0000_1000;

    axi_rd_arbiter #(
        .NUM_REQ        (NR),
        .AXI_DATA_WIDTH (DW),
        .MAX_OUTST      (MO)
    ) dut (
        .ACLK            (ACLK),
        .ARESETN         (ARESETN),
        .req_ar          (req_ar),
        .req_ar_vld      (req_ar_vld),
        .req_ar_ack      (req_ar_ack),
        .req_r           (req_r),
        .req_r_vld       (req_r_vld),
        .req_r_ack       (req_r_ack),
        .axi_ar_V        (axi_ar_V),
        .axi_ar_V_ap_vld (axi_ar_V_ap_vld),
        .axi_ar_V_ap_ack (axi_ar_V_ap_ack),
        .axi_r_V         (axi_r_V),
        .axi_r_V_ap_vld  (axi_r_V_ap_vld),
        .axi_r_V_ap_ack  (axi_r_V_ap_ack)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Grant cycle, optional stall cycles in ISSUE, then the downstream AR ack cycle.
    task automatic ar_grant(input logic [NR-1:0] exp_ack, input logic [39:0] exp_word, input int hold);
        logic [39:0] e;
        #1;
        check("ar_ack", 64'(req_ar_ack), 64'(exp_ack));
        check("ar_vld_c0", 64'(axi_ar_V_ap_vld), 64'(1'b0));
        ar_sb.push_back(exp_word);
        tick();
        for (int i = 0; i < hold; i++) begin
            #1;
            check("ar_hold_word", 64'(axi_ar_V), 64'(ar_sb[0]));
            check("ar_hold_vld", 64'(axi_ar_V_ap_vld), 64'(1'b1));
            tick();
        end
        axi_ar_V_ap_ack = 1'b1;
        #1;
        check("ar_no_ack_in_issue", 64'(req_ar_ack), 64'(0));
        if (axi_ar_V_ap_vld) begin
            e = ar_sb.pop_front();
            check("ar_word", 64'(axi_ar_V), 64'(e));
        end else begin
            check("ar_vld", 64'(axi_ar_V_ap_vld), 64'(1'b1));
        end
        tick();
        axi_ar_V_ap_ack = 1'b0;
    endtask

    // Drive one R beat and compare against the scoreboard when it transfers.
    task automatic beat_now(input logic [NR-1:0] exp_vld, input logic [DW:0] word, input logic [NR-1:0] rack);
        r_exp_t e;
        r_exp_t n;
        n.vld  = exp_vld;
        n.word = word;
        r_sb.push_back(n);
        axi_r_V        = word;
        axi_r_V_ap_vld = 1'b1;
        req_r_ack      = rack;
        #1;
        if (axi_r_V_ap_ack) begin
            e = r_sb.pop_front();
            check("r_vld", 64'(req_r_vld), 64'(e.vld));
            check("r_data", 64'(req_r), 64'(e.word));
        end else begin
            check("r_ack", 64'(axi_r_V_ap_ack), 64'(1'b1));
        end
    endtask

    task automatic stray_beat(input string tag);
        axi_r_V        = {1'b1, 32'hDEAD_BEEF};
        axi_r_V_ap_vld = 1'b1;
        req_r_ack      = '1;
        #1;
        check({tag, "_ack"}, 64'(axi_r_V_ap_ack), 64'(1'b0));
        check({tag, "_vld"}, 64'(req_r_vld), 64'(0));
        tick();
        axi_r_V_ap_vld = 1'b0;
        req_r_ack      = '0;
    endtask

    initial begin
        ARESETN         = 1'b0;
        req_ar          = '0;
        req_ar_vld      = '0;
        req_r_ack       = '0;
        axi_ar_V_ap_ack = 1'b0;
        axi_r_V         = '0;
        axi_r_V_ap_vld  = 1'b0;
        repeat (2) @(posedge ACLK);
        #2;
        check("rst_ar_ack", 64'(req_ar_ack), 64'(0));
        check("rst_r_vld", 64'(req_r_vld), 64'(0));
        check("rst_ar_vld", 64'(axi_ar_V_ap_vld), 64'(0));
        check("rst_ar_word", 64'(axi_ar_V), 64'(0));
        check("rst_r_ack", 64'(axi_r_V_ap_ack), 64'(0));
        ARESETN = 1'b1;
        tick();

        // Single request from requester 1, one stall cycle, 4-beat burst.
        req_ar[0 +: 40]  = W0;
        req_ar[40 +: 40] = W1;
        req_ar_vld = 2'b10;
        ar_grant(2'b10, W1, 1);
        req_ar_vld = 2'b00;
        for (int b = 0; b < 4; b++) begin
            beat_now(2'b10, {(b == 3), 32'hA000_0000 + 32'(b)}, 2'b11);
            tick();
        end
        axi_r_V_ap_vld = 1'b0;
        stray_beat("empty_after_burst");

        // Contention alternates; a lone requester right after its own grant is granted again.
        req_ar_vld = 2'b11;
        ar_grant(2'b01, W0, 0);
        ar_grant(2'b10, W1, 0);
        req_ar_vld = 2'b10;
        ar_grant(2'b10, W1, 0);
        req_ar_vld = 2'b11;
        ar_grant(2'b01, W0, 0);

        // Four bursts outstanding: no grant until an RLAST pops the FIFO.
        #1;
        check("full_no_ack_a", 64'(req_ar_ack), 64'(0));
        tick();
        #1;
        check("full_no_ack_b", 64'(req_ar_ack), 64'(0));
        tick();
        beat_now(2'b01, {1'b1, 32'hB000_0000}, 2'b11);
        check("full_same_cycle", 64'(req_ar_ack), 64'(0));
        tick();
        axi_r_V_ap_vld = 1'b0;
        ar_grant(2'b10, W1, 0);
        req_ar_vld = 2'b00;

        // Owner backpressure; only the non-owner acks.
        axi_r_V        = {1'b1, 32'hC000_0000};
        axi_r_V_ap_vld = 1'b1;
        req_r_ack      = 2'b01;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_ack", 64'(axi_r_V_ap_ack), 64'(0));
            check("bp_vld", 64'(req_r_vld), 64'(2'b10));
            check("bp_word", 64'(req_r), 64'({1'b1, 32'hC000_0000}));
            tick();
        end
        beat_now(2'b10, {1'b1, 32'hC000_0000}, 2'b10);
        tick();
        beat_now(2'b10, {1'b1, 32'hC000_0001}, 2'b11);
        tick();
        beat_now(2'b01, {1'b1, 32'hC000_0002}, 2'b11);
        tick();
        beat_now(2'b10, {1'b1, 32'hC000_0003}, 2'b11);
        tick();
        axi_r_V_ap_vld = 1'b0;
        stray_beat("empty_after_drain");

        // Ordering with a push and a pop in the same cycle.
        req_ar_vld = 2'b01;
        ar_grant(2'b01, W0, 0);
        req_ar_vld = 2'b10;
        beat_now(2'b01, {1'b0, 32'hD000_0000}, 2'b11);
        check("ord_ar_ack", 64'(req_ar_ack), 64'(2'b10));
        tick();
        req_ar_vld      = 2'b00;
        axi_ar_V_ap_ack = 1'b1;
        beat_now(2'b01, {1'b1, 32'hD000_0001}, 2'b11);
        check("ord_ar_word", 64'(axi_ar_V), 64'(W1));
        check("ord_ar_vld", 64'(axi_ar_V_ap_vld), 64'(1'b1));
        tick();
        axi_ar_V_ap_ack = 1'b0;
        beat_now(2'b10, {1'b1, 32'hD000_0002}, 2'b11);
        tick();
        axi_r_V_ap_vld = 1'b0;
        stray_beat("empty_after_order");

        // Reset in ISSUE with two bursts outstanding.
        req_ar_vld = 2'b10;
        ar_grant(2'b10, W1, 0);
        req_ar_vld = 2'b01;
        ar_grant(2'b01, W0, 0);
        req_ar_vld = 2'b10;
        #1;
        check("pre_rst_ack", 64'(req_ar_ack), 64'(2'b10));
        tick();
        axi_r_V        = {1'b1, 32'hE000_0000};
        axi_r_V_ap_vld = 1'b1;
        req_r_ack      = 2'b00;
        #1;
        check("pre_rst_issue", 64'(axi_ar_V_ap_vld), 64'(1'b1));
        check("pre_rst_r_vld", 64'(req_r_vld), 64'(2'b10));
        #1;
        ARESETN = 1'b0;
        #1;
        check("mid_rst_ar_vld", 64'(axi_ar_V_ap_vld), 64'(0));
        check("mid_rst_ar_word", 64'(axi_ar_V), 64'(0));
        check("mid_rst_ar_ack", 64'(req_ar_ack), 64'(0));
        check("mid_rst_r_vld", 64'(req_r_vld), 64'(0));
        check("mid_rst_r_ack", 64'(axi_r_V_ap_ack), 64'(0));
        tick();
        axi_r_V_ap_vld = 1'b0;
        req_ar_vld     = 2'b11;
        ARESETN        = 1'b1;
        ar_grant(2'b01, W0, 0);
        req_ar_vld = 2'b00;
        beat_now(2'b01, {1'b1, 32'hE000_0001}, 2'b11);
        tick();
        axi_r_V_ap_vld = 1'b0;
        stray_beat("empty_after_reset");

        check("r_sb_drained", 64'(r_sb.size()), 64'(0));
        check("ar_sb_drained", 64'(ar_sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
